// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the pipeline-stage skid register: state encoding and occupancy width.
package pipe_stage_skid_pkg;

    localparam int SKID_OCC_W = 2;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_BUSY  = 2'd1,
        SK_FULL  = 2'd2
    } skid_state_e;

    // Number of entries held in a given state.
    function automatic logic [SKID_OCC_W-1:0] occ_of(input skid_state_e st);
        case (st)
            SK_EMPTY: occ_of = 2'd0;
            SK_BUSY:  occ_of = 2'd1;
            SK_FULL:  occ_of = 2'd2;
            default:  occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         synclr_ni,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count register, held at all-ones once reached.
    always_ff @(posedge clk_i or negedge synclr_ni) begin
        if (!synclr_ni) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, two-entry skid buffer,
// registered upstream ready, synchronous flush and a saturating stall counter.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter bit CLR_DATA = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic                  clk_i,
    input  logic                  synclr_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     out_data_o,
    output logic [SKID_OCC_W-1:0] occ_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    input  logic                  cnt_clr_i
);

    skid_state_e           state_r;
    skid_state_e           state_s;
    logic [DATA_W-1:0]     main_r;
    logic [DATA_W-1:0]     skid_r;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic [SKID_OCC_W-1:0] occ_r;
    logic                  in_fire_s;
    logic                  out_fire_s;
    logic                  ld_main_in_s;
    logic                  ld_main_skid_s;
    logic                  ld_skid_s;
    logic                  stall_s;

    assign in_fire_s  = in_valid_i & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready_i;
    assign stall_s    = out_valid_r & ~out_ready_i;

    // Next-state and storage load decisions; flush overrides everything.
    always_comb begin
        state_s        = state_r;
        ld_main_in_s   = 1'b0;
        ld_main_skid_s = 1'b0;
        ld_skid_s      = 1'b0;
        case (state_r)
            SK_EMPTY: begin
                if (in_fire_s) begin
                    state_s      = SK_BUSY;
                    ld_main_in_s = 1'b1;
                end else begin
                    state_s = SK_EMPTY;
                end
            end
            SK_BUSY: begin
                if (in_fire_s && !out_fire_s) begin
                    state_s   = SK_FULL;
                    ld_skid_s = 1'b1;
                end else if (!in_fire_s && out_fire_s) begin
                    state_s = SK_EMPTY;
                end else if (in_fire_s && out_fire_s) begin
                    state_s      = SK_BUSY;
                    ld_main_in_s = 1'b1;
                end else begin
                    state_s = SK_BUSY;
                end
            end
            SK_FULL: begin
                if (out_fire_s) begin
                    state_s        = SK_BUSY;
                    ld_main_skid_s = 1'b1;
                end else begin
                    state_s = SK_FULL;
                end
            end
            default: begin
                state_s = SK_EMPTY;
            end
        endcase
        if (flush_i) begin
            state_s        = SK_EMPTY;
            ld_main_in_s   = 1'b0;
            ld_main_skid_s = 1'b0;
            ld_skid_s      = 1'b0;
        end else begin
            state_s = state_s;
        end
    end

    // State and handshake flags; ready/valid/occupancy are decoded from the
    // next state so every output comes straight from a flop.
    always_ff @(posedge clk_i or negedge synclr_ni) begin
        if (!synclr_ni) begin
            state_r     <= SK_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            occ_r       <= 2'd0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s != SK_FULL);
            out_valid_r <= (state_s != SK_EMPTY);
            occ_r       <= occ_of(state_s);
        end
    end

    // Payload storage: main feeds the output, skid catches the in-flight beat.
    always_ff @(posedge clk_i or negedge synclr_ni) begin
        if (!synclr_ni) begin
            main_r <= '0;
            skid_r <= '0;
        end else if (flush_i) begin
            if (CLR_DATA) begin
                main_r <= '0;
                skid_r <= '0;
            end
        end else begin
            if (ld_main_in_s) begin
                main_r <= in_data_i;
            end else if (ld_main_skid_s) begin
                main_r <= skid_r;
            end
            if (ld_skid_s) begin
                skid_r <= in_data_i;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i     (clk_i),
        .synclr_ni (synclr_ni),
        .inc       (stall_s),
        .clr       (cnt_clr_i),
        .count     (stall_cnt_o)
    );

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign out_data_o  = main_r;
    assign occ_o       = occ_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, corner sequences and a
// randomized run against a queue-based reference model. Two instances share
// stimulus: CLR_DATA=1/CNT_W=4 and CLR_DATA=0/CNT_W=16.
module tb_pipe_stage_skid;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic          cnt_clr;
    logic [DW-1:0] in_data;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DW-1:0] data1, data0;
    logic [1:0]    occ1, occ0;
    logic [3:0]    cnt1;
    logic [15:0]   cnt0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CLR_DATA(1'b1), .CNT_W(4)) dut (
        .clk_i(clk), .synclr_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready1), .in_data_i(in_data),
        .out_valid_o(out_valid1), .out_ready_i(out_ready), .out_data_o(data1),
        .occ_o(occ1), .stall_cnt_o(cnt1), .cnt_clr_i(cnt_clr)
    );

    pipe_stage_skid #(.DATA_W(DW), .CLR_DATA(1'b0), .CNT_W(16)) dut0 (
        .clk_i(clk), .synclr_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready0), .in_data_i(in_data),
        .out_valid_o(out_valid0), .out_ready_i(out_ready), .out_data_o(data0),
        .occ_o(occ0), .stall_cnt_o(cnt0), .cnt_clr_i(cnt_clr)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        clr;
        int          occ;
        logic        valid;
        logic        rdy;
        logic [31:0] d1;
        logic [31:0] d0;
        int          cnt;
    } vec_t;

    vec_t vecs[15];

    // Reference model: queue of held payloads, raw stall count, last shown data.
    logic [31:0] q[$];
    int          raw_cnt;
    logic [31:0] sh1, sh0;

    function automatic vec_t mk(input logic fl, iv, input logic [31:0] din,
                                input logic ordy, clr, input int occ,
                                input logic valid, rdy, input logic [31:0] d1, d0,
                                input int cnt);
        vec_t v;
        v.fl = fl; v.iv = iv; v.din = din; v.ordy = ordy; v.clr = clr;
        v.occ = occ; v.valid = valid; v.rdy = rdy; v.d1 = d1; v.d0 = d0; v.cnt = cnt;
        return v;
    endfunction

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int occ, input logic v, r,
                             input logic [31:0] d1, d0, input int c1, c0);
        chk({tag, ".occ"},    32'(occ1),       32'(occ));
        chk({tag, ".occ0"},   32'(occ0),       32'(occ));
        chk({tag, ".valid"},  32'(out_valid1), 32'(v));
        chk({tag, ".valid0"}, 32'(out_valid0), 32'(v));
        chk({tag, ".ready"},  32'(in_ready1),  32'(r));
        chk({tag, ".ready0"}, 32'(in_ready0),  32'(r));
        chk({tag, ".data"},   data1,           d1);
        chk({tag, ".data0"},  data0,           d0);
        chk({tag, ".cnt"},    32'(cnt1),       32'(c1));
        chk({tag, ".cnt0"},   32'(cnt0),       32'(c0));
    endtask

    task automatic drive(input logic fl, iv, input logic [31:0] din,
                         input logic ordy, clr);
        flush = fl; in_valid = iv; in_data = din; out_ready = ordy; cnt_clr = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance the model by one edge using the inputs applied this cycle.
    task automatic model_step(input logic fl, iv, input logic [31:0] din,
                              input logic ordy, clr);
        bit inf, outf, st;
        inf  = iv && (q.size() < 2);
        outf = ordy && (q.size() > 0);
        st   = (q.size() > 0) && !ordy;
        if (clr) raw_cnt = 0;
        else if (st) raw_cnt++;
        if (fl) begin
            q.delete();
            sh1 = 32'h0;
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back(din);
        end
        if (q.size() > 0) begin
            sh1 = q[0];
            sh0 = q[0];
        end
    endtask

    initial begin
        logic fl, iv, ordy, clr;
        logic [31:0] din;
        int pct;

        // streaming
        vecs[0]  = mk(0, 1, 32'h11, 1, 0, 1, 1, 1, 32'h11, 32'h11, 0);
        vecs[1]  = mk(0, 1, 32'h22, 1, 0, 1, 1, 1, 32'h22, 32'h22, 0);
        vecs[2]  = mk(0, 1, 32'h33, 1, 0, 1, 1, 1, 32'h33, 32'h33, 0);
        vecs[3]  = mk(0, 0, 32'h00, 1, 0, 0, 0, 1, 32'h33, 32'h33, 0);
        // backpressure, 0xC held off while full
        vecs[4]  = mk(0, 1, 32'h0A, 0, 0, 1, 1, 1, 32'h0A, 32'h0A, 0);
        vecs[5]  = mk(0, 1, 32'h0B, 0, 0, 2, 1, 0, 32'h0A, 32'h0A, 1);
        vecs[6]  = mk(0, 1, 32'h0C, 0, 0, 2, 1, 0, 32'h0A, 32'h0A, 2);
        vecs[7]  = mk(0, 1, 32'h0C, 1, 0, 1, 1, 1, 32'h0B, 32'h0B, 2);
        vecs[8]  = mk(0, 1, 32'h0C, 1, 0, 1, 1, 1, 32'h0C, 32'h0C, 2);
        vecs[9]  = mk(0, 0, 32'h00, 1, 0, 0, 0, 1, 32'h0C, 32'h0C, 2);
        // flush while full with a concurrent 0xD push
        vecs[10] = mk(0, 1, 32'h01, 0, 0, 1, 1, 1, 32'h01, 32'h01, 2);
        vecs[11] = mk(0, 1, 32'h02, 0, 0, 2, 1, 0, 32'h01, 32'h01, 3);
        vecs[12] = mk(1, 1, 32'h0D, 0, 0, 0, 0, 1, 32'h00, 32'h01, 4);
        vecs[13] = mk(0, 0, 32'h00, 1, 0, 0, 0, 1, 32'h00, 32'h01, 4);
        vecs[14] = mk(0, 0, 32'h00, 1, 1, 0, 0, 1, 32'h00, 32'h01, 0);

        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0);
        step();
        step();
        check_all("reset", 0, 0, 1, 32'h0, 32'h0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].clr);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].occ, vecs[i].valid, vecs[i].rdy,
                      vecs[i].d1, vecs[i].d0, vecs[i].cnt, vecs[i].cnt);
        end

        // saturation: one held beat stalled for 20 cycles
        drive(0, 1, 32'h77, 0, 0);
        step();
        repeat (20) begin
            drive(0, 0, 32'h0, 0, 0);
            step();
        end
        check_all("sat", 1, 1, 1, 32'h77, 32'h77, 15, 20);
        drive(0, 0, 32'h0, 0, 1);
        step();
        check_all("satclr", 1, 1, 1, 32'h77, 32'h77, 0, 0);
        drive(0, 1, 32'h88, 0, 0);
        step();
        check_all("fill", 2, 1, 0, 32'h77, 32'h77, 1, 1);

        // asynchronous reset between edges while full
        drive(0, 0, 32'h0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("areset", 0, 0, 1, 32'h0, 32'h0, 0, 0);
        step();
        rst_n = 1'b1;
        drive(0, 1, 32'h5, 1, 0);
        step();
        check_all("postrst", 1, 1, 1, 32'h5, 32'h5, 0, 0);
        drive(0, 0, 32'h0, 1, 0);
        step();
        check_all("drain", 0, 0, 1, 32'h5, 32'h5, 0, 0);

        // randomized run against the reference model
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        q.delete();
        raw_cnt = 0;
        sh1 = 32'h0;
        sh0 = 32'h0;
        for (int i = 0; i < 10000; i++) begin
            pct  = ((i / 500) % 4) * 30 + 5;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 99) < pct);
            fl   = ($urandom_range(0, 63) == 0);
            clr  = ($urandom_range(0, 127) == 0);
            din  = $urandom;
            drive(fl, iv, din, ordy, clr);
            model_step(fl, iv, din, ordy, clr);
            step();
            check_all("rnd", q.size(), q.size() > 0, q.size() < 2, sh1, sh0,
                      sat(raw_cnt, 15), sat(raw_cnt, 65535));
            if (occ1 == 2'd2) chk("rnd.ready_when_full", 32'(in_ready1), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake and a two-entry skid buffer. It replaces the fixed-payload, enable-only inter-stage flip-flops between IF/ID/EX/MEM/WB. Payload width is a parameter, so any stage struct is carried packed. Upstream ready is fully registered, which breaks the combinational stall path across stages; the block also supports synchronous flush, optional payload zeroing, and a saturating stall-cycle counter for performance monitoring.

## Interface
- DATA_W, 32, payload width in bits (set to $bits of the stage struct)
- CLR_DATA, 1, 1: payload registers zeroed on reset/flush; 0: only valid state cleared
- CNT_W, 16, stall counter width

- clk_i  in  1  clock, rising edge
- synclr_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous flush, drops all held entries
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  block can accept (registered)
- in_data_i  in  DATA_W  upstream payload
- out_valid_o  out  1  downstream payload valid
- out_ready_i  in  1  downstream accepts
- out_data_o  out  DATA_W  downstream payload (driven from main register)
- occ_o  out  2  entries held (0..2)
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating
- cnt_clr_i  in  1  synchronous clear of stall_cnt_o

## Operation
- in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Storage: main register (feeds out_data_o) and skid register.
- State machine (SK_EMPTY, SK_BUSY, SK_FULL); occ_o = 0/1/2 respectively:
  - EMPTY: in_fire -> BUSY, main <= in_data_i; otherwise stay.
  - BUSY: in_fire & !out_fire -> FULL, skid <= in_data_i; !in_fire & out_fire -> EMPTY; in_fire & out_fire -> BUSY, main <= in_data_i; neither -> stay.
  - FULL: out_fire -> BUSY, main <= skid; otherwise stay. in_valid_i is ignored (in_ready_o=0).
- out_valid_o = (state != EMPTY). in_ready_o is a flop equal to (next_state != FULL).
- flush_i=1: next state EMPTY; in_fire that cycle is discarded; out_fire that cycle is still counted as delivered downstream. If CLR_DATA=1, main and skid are zeroed.
- Stall counter: +1 each cycle with out_valid_o & !out_ready_i, held at 2^CNT_W-1. cnt_clr_i has priority over increment. flush_i does not clear it.
- Reset: state EMPTY, in_ready_o=1, out_valid_o=0, occ_o=0, stall_cnt_o=0, out_data_o=0 (regardless of CLR_DATA).
- With CLR_DATA=0, out_data_o holds its last value while invalid.

## Timing
- Latency: payload accepted at edge N appears on out_data_o with out_valid_o=1 after edge N (visible in cycle N+1).
- Throughput: 1 transfer/cycle sustained when out_ready_i=1.
- in_ready_o falls one cycle after the stall that fills the skid register. No combinational path from out_ready_i to in_ready_o.
- Flush takes effect at the next edge; in_ready_o=1 and out_valid_o=0 from the following cycle.
- Reset deassertion: in_fire is permitted in the first cycle after release.
- Ordering: payloads leave in acceptance order; none are lost or duplicated except by flush.

## Structure
- In StructPkg: typedef enum logic [1:0] skid_state_e {SK_EMPTY, SK_BUSY, SK_FULL}; and localparam SKID_OCC_W = 2.
- Stage structs (e.g. EX_MEM_ff) are packed at instantiation: in_data_i = EX_i, MEM_o = EX_MEM_ff'(out_data_o).
- Sub-module sat_counter (parameter W; inputs inc, clr; output count) implements stall_cnt_o.

## Test plan
- Streaming: reset, out_ready_i=1, push 0x11,0x22,0x33 on consecutive cycles -> same values on out_data_o one cycle later each; occ_o stays 1; in_ready_o stays 1; stall_cnt_o=0.
- Backpressure: out_ready_i=0, push 0xA, 0xB -> occ_o=2, in_ready_o=0 next cycle; 0xC held off. Release ready -> out 0xA, 0xB, 0xC in order; stall_cnt_o equals the stalled cycles.
- Flush while FULL with CLR_DATA=1, plus concurrent in_valid_i with 0xD -> next cycle occ_o=0, out_valid_o=0, out_data_o=0; 0xD never appears.
- Saturation: CNT_W=4, hold out_valid_o=1 with out_ready_i=0 for 20 cycles -> stall_cnt_o=15. Then cnt_clr_i together with a stall -> 0.
- Async reset mid-stream: drop synclr_ni between edges while FULL -> outputs go immediately to the reset values. Push 0x5 in the first cycle after release -> it appears next cycle.
- Random valid/ready for 10k cycles against a scoreboard queue -> no loss, reorder or duplication, and in_ready_o never 1 when occ_o=2.
